imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 135 +++++++++++++
 tb/tb_imem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter.
// A boot loader owns the single memory port until it signals end-of-boot.
// After that, instruction fetch and the loader share the port round-robin,
// and a starvation guard keeps fetch from waiting too long behind the loader.
//
//   state | meaning
//   BOOT  | only loader writes are granted; fetch waits
//   RUN   | fetch and loader arbitrated round-robin with starve guard
module imem_arbiter #(
  parameter int IMEM_W     = 13,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_f_req,
  input  logic [IMEM_W-1:0] i_f_addr,
  output logic              o_f_gnt,
  output logic              o_f_rvalid,
  output logic [31:0]       o_f_rdata,
  output logic              o_f_misalign,
  input  logic              i_l_req,
  input  logic [IMEM_W-1:0] i_l_addr,
  input  logic [31:0]       i_l_wdata,
  output logic              o_l_gnt,
  input  logic              i_l_done,
  output logic              o_boot,
  output logic [IMEM_W-2:0] o_load_cnt,
  output logic              o_m_en,
  output logic              o_m_we,
  output logic [IMEM_W-3:0] o_m_addr,
  output logic [31:0]       o_m_wdata,
  input  logic [31:0]       i_m_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic              last_l_q;
  logic [SW-1:0]     starve_q;
  logic              f_gnt, l_gnt;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              misalign_q;
  logic [IMEM_W-2:0] load_cnt_q;
  logic              starved;
  logic              unused_l_lsb;

  // Loader writes are word-aligned by construction; its byte offset is dropped.
  assign unused_l_lsb = ^i_l_addr[1:0];

  assign starved = (starve_q >= SW'(STARVE_MAX));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  // Next state and grants; grants are held off while reset is asserted.
  always_comb begin
    state_d = state_q;
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    if (i_rst_n) begin
      case (state_q)
        ST_BOOT: begin
          l_gnt = i_l_req;
          if (i_l_done) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (i_f_req && i_l_req) begin
            f_gnt = starved || last_l_q;
            l_gnt = !f_gnt;
          end else begin
            f_gnt = i_f_req;
            l_gnt = i_l_req;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  // Round-robin pointer and starve counter; both only advance in RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_l_q <= 1'b0;
      starve_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (f_gnt)      last_l_q <= 1'b0;
      else if (l_gnt) last_l_q <= 1'b1;
      if (f_gnt || !i_f_req)      starve_q <= '0;
      else if (l_gnt && !starved) starve_q <= starve_q + 1'b1;
    end else begin
      starve_q <= '0;
    end
  end

  // Fetch read return: valid one cycle after grant, data held between reads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= f_gnt;
      if (rvalid_q) rdata_q <= i_m_rdata;
    end
  end

  // Sticky misalign flag and saturating loader word count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      misalign_q <= 1'b0;
      load_cnt_q <= '0;
    end else begin
      if (f_gnt && (i_f_addr[1:0] != 2'b00)) misalign_q <= 1'b1;
      if (l_gnt && !(&load_cnt_q))           load_cnt_q <= load_cnt_q + 1'b1;
    end
  end

  assign o_f_gnt      = f_gnt;
  assign o_l_gnt      = l_gnt;
  assign o_f_rvalid   = rvalid_q;
  assign o_f_rdata    = rvalid_q ? i_m_rdata : rdata_q;
  assign o_f_misalign = misalign_q;
  assign o_load_cnt   = load_cnt_q;
  assign o_boot       = (state_q == ST_BOOT);
  assign o_m_en       = f_gnt | l_gnt;
  assign o_m_we       = l_gnt;
  assign o_m_addr     = l_gnt ? i_l_addr[IMEM_W-1:2] : i_f_addr[IMEM_W-1:2];
  assign o_m_wdata    = i_l_wdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: memory model, fetch-data scoreboard, directed phases.
module tb_imem_arbiter;
  localparam int IMEM_W = 13;
  localparam int SMAX   = 4;
  localparam int NW     = 2 ** (IMEM_W - 2);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              f_req, l_req, l_done;
  logic [IMEM_W-1:0] f_addr, l_addr;
  logic [31:0]       l_wdata;
  logic              f_gnt, f_rvalid, f_misalign, l_gnt, boot;
  logic [31:0]       f_rdata, m_wdata, m_rdata;
  logic [IMEM_W-2:0] load_cnt;
  logic              m_en, m_we;
  logic [IMEM_W-3:0] m_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];
  logic [31:0] exp_q   [$];
  logic [31:0] last_rd;

  imem_arbiter #(.IMEM_W(IMEM_W), .STARVE_MAX(SMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
    .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata), .o_f_misalign(f_misalign),
    .i_l_req(l_req), .i_l_addr(l_addr), .i_l_wdata(l_wdata), .o_l_gnt(l_gnt),
    .i_l_done(l_done), .o_boot(boot), .o_load_cnt(load_cnt),
    .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous memory: one-cycle read latency.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  // Scoreboard: push expected word on fetch grant, pop on read-valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_rd = 32'h0;
    end else begin
      if (f_rvalid) begin
        if (exp_q.size() == 0) chk("rvalid_unexp", 32'd1, 32'd0);
        else begin
          last_rd = exp_q.pop_front();
          chk("rdata", f_rdata, last_rd);
        end
      end else begin
        chk("rdata_hold", f_rdata, last_rd);
      end
      if (f_gnt) exp_q.push_back(ref_mem[f_addr[IMEM_W-1:2]]);
      if (l_gnt) ref_mem[l_addr[IMEM_W-1:2]] = l_wdata;
    end
  end

  int exp_ld;
  int run, max_run;

  initial begin
    for (int i = 0; i < NW; i++) begin
      mem[i]     = 32'hDEAD_0000 | i;
      ref_mem[i] = 32'hDEAD_0000 | i;
    end
    m_rdata = 32'h0;
    rst_n = 1'b0; f_req = 1'b1; f_addr = 13'h004;
    l_req = 1'b1; l_addr = '0; l_wdata = 32'h0; l_done = 1'b0;
    exp_ld = 0;

    // Reset state, with both requests asserted.
    @(negedge clk); @(negedge clk);
    chk("rst_boot", boot, 1); chk("rst_fgnt", f_gnt, 0); chk("rst_lgnt", l_gnt, 0);
    chk("rst_rvalid", f_rvalid, 0); chk("rst_rdata", f_rdata, 0);
    chk("rst_mis", f_misalign, 0); chk("rst_cnt", load_cnt, 0);
    chk("rst_men", m_en, 0); chk("rst_mwe", m_we, 0);
    l_req = 1'b0;
    tick();
    rst_n = 1'b1;

    // Boot load with fetch waiting.
    for (int i = 0; i < 3; i++) begin
      l_req = 1'b1; l_addr = IMEM_W'(4 * i); l_wdata = 32'hA000_0000 + i;
      @(negedge clk);
      chk("boot_lgnt", l_gnt, 1); chk("boot_fgnt", f_gnt, 0);
      chk("boot_maddr", m_addr, i); chk("boot_mwe", m_we, 1);
      chk("boot_wdata", m_wdata, 32'hA000_0000 + i);
      exp_ld++;
      tick();
    end
    l_req = 1'b0;
    @(negedge clk);
    chk("boot_cnt", load_cnt, 3); chk("boot_fgnt_idle", f_gnt, 0); chk("boot_men", m_en, 0);
    tick();

    // Boot exit with a write in the done cycle, then first fetch.
    f_req = 1'b0; l_req = 1'b1; l_addr = 13'h00C; l_wdata = 32'hA000_0003; l_done = 1'b1;
    @(negedge clk);
    chk("done_lgnt", l_gnt, 1); chk("done_boot", boot, 1);
    exp_ld++;
    tick();
    l_req = 1'b0; l_done = 1'b0; f_req = 1'b1; f_addr = 13'h004;
    @(negedge clk);
    chk("run_boot", boot, 0); chk("run_fgnt", f_gnt, 1);
    chk("run_maddr", m_addr, 1); chk("run_mwe", m_we, 0);
    tick();
    f_req = 1'b0;
    @(negedge clk);
    chk("run_rvalid", f_rvalid, 1);
    tick();

    // Contention: last grant was fetch, so loader wins first.
    f_req = 1'b1; f_addr = 13'h008;
    for (int i = 0; i < 8; i++) begin
      l_req = 1'b1; l_addr = IMEM_W'(13'h100 + 4 * (i / 2)); l_wdata = 32'hB000_0000 + (i / 2);
      @(negedge clk);
      chk("rr_lgnt", l_gnt, (i % 2 == 0));
      chk("rr_fgnt", f_gnt, (i % 2 == 1));
      tick();
    end
    exp_ld += 4;

    // Loader alone sets pointer to loader, then hold both.
    f_req = 1'b0; l_req = 1'b1; l_addr = 13'h200; l_wdata = 32'hC000_0000;
    @(negedge clk);
    chk("solo_lgnt", l_gnt, 1);
    exp_ld++;
    tick();
    f_req = 1'b1; f_addr = 13'h00C;
    run = 0; max_run = 0;
    for (int i = 0; i < 10; i++) begin
      l_addr = IMEM_W'(13'h204 + 4 * ((i + 1) / 2)); l_wdata = 32'hC000_0001 + ((i + 1) / 2);
      @(negedge clk);
      chk("st_fgnt", f_gnt, (i % 2 == 0));
      chk("st_lgnt", l_gnt, (i % 2 == 1));
      if (l_gnt) run++; else run = 0;
      if (run > max_run) max_run = run;
      tick();
    end
    exp_ld += 5;
    chk("starve_run", (max_run <= SMAX), 1);
    chk("run_cnt", load_cnt, exp_ld);

    // End-of-boot pulse in RUN is ignored.
    f_req = 1'b0; l_req = 1'b0; l_done = 1'b1;
    tick();
    l_done = 1'b0;
    @(negedge clk);
    chk("done_ign", boot, 0);
    tick();

    // Misaligned fetch, then aligned fetch keeps the flag.
    f_req = 1'b1; f_addr = 13'h006;
    @(negedge clk);
    chk("mis_fgnt", f_gnt, 1); chk("mis_maddr", m_addr, 1); chk("mis_men", m_en, 1);
    chk("mis_pre", f_misalign, 0);
    tick();
    f_addr = 13'h000;
    @(negedge clk);
    chk("mis_set", f_misalign, 1);
    tick();
    f_req = 1'b0;
    @(negedge clk);
    chk("mis_stay", f_misalign, 1);
    tick();
    tick();

    // Reset the cycle after a fetch grant.
    f_req = 1'b1; f_addr = 13'h008;
    @(negedge clk);
    chk("pre_rst_fgnt", f_gnt, 1);
    tick();
    f_req = 1'b0;
    rst_n = 1'b0; l_req = 1'b1;
    #1;
    chk("ar_rvalid", f_rvalid, 0); chk("ar_boot", boot, 1); chk("ar_cnt", load_cnt, 0);
    chk("ar_men", m_en, 0); chk("ar_lgnt", l_gnt, 0); chk("ar_rdata", f_rdata, 0);
    chk("ar_mis", f_misalign, 0);
    tick(); tick();
    l_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_boot", boot, 1); chk("post_rvalid", f_rvalid, 0);
    tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
